// File: rtl/ww_pkg.sv
// Shared definitions for the WideWord writeback stage: participation/width
// codes and the queued register-file write entry.
package ww_pkg;

    localparam int unsigned WB_DATA_W = 128;
    localparam int unsigned WB_ADDR_W = 5;

    typedef enum logic [2:0] {
        PPP_ALL   = 3'b000,
        PPP_UPPER = 3'b001,
        PPP_LOWER = 3'b010,
        PPP_EVEN  = 3'b011,
        PPP_ODD   = 3'b100
    } ppp_e;

    typedef enum logic [1:0] {
        WW_B = 2'b00,
        WW_H = 2'b01,
        WW_W = 2'b10,
        WW_D = 2'b11
    } ww_e;

    typedef struct packed {
        logic [WB_ADDR_W-1:0]   rd;
        logic [WB_DATA_W-1:0]   data;
        logic [WB_DATA_W/8-1:0] byteen;
    } wb_entry_t;

endpackage

// File: rtl/ww_byteen_gen.sv
// Expands a PPP/WW participation pair into a per-byte write enable mask.
module ww_byteen_gen
    import ww_pkg::*;
#(
    parameter int unsigned NB = 16
) (
    input  logic [2:0]    ppp,
    input  logic [1:0]    ww,
    output logic [NB-1:0] byteen,
    output logic          reserved
);

    localparam int unsigned HALF = NB / 2;

    always_comb begin
        byteen   = '0;
        reserved = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            // element index of byte i is i >> ww; its parity picks even/odd
            case (ppp)
                PPP_ALL:   byteen[i] = 1'b1;
                PPP_UPPER: byteen[i] = (i >= HALF);
                PPP_LOWER: byteen[i] = (i < HALF);
                PPP_EVEN:  byteen[i] = (((i >> ww) & 32'd1) == 32'd0);
                PPP_ODD:   byteen[i] = (((i >> ww) & 32'd1) == 32'd1);
                default:   reserved  = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ww_writeback_stage.sv
// WideWord final stage: merges ALU and load results through a 2-entry FIFO
// onto the single register-file write port and exports pending writes.
module ww_writeback_stage
    import ww_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic [2:0]          alu_ppp,
    input  logic [1:0]          alu_ww,
    input  logic                ld_valid,
    input  logic [ADDR_W-1:0]   ld_rd,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic [2:0]          ld_ppp,
    input  logic [1:0]          ld_ww,
    output logic                stall,
    output logic                wren,
    output logic [ADDR_W-1:0]   wraddr,
    output logic [DATA_W-1:0]   wrdata,
    output logic [DATA_W/8-1:0] wrbyteen,
    output logic [NREG-1:0]     pending,
    output logic                err
);

    localparam int unsigned NB = DATA_W / 8;

    wb_entry_t     q [2];
    logic [1:0]    q_cnt;

    logic [NB-1:0] ld_be, alu_be;
    logic          ld_rsv, alu_rsv;

    ww_byteen_gen #(.NB(NB)) u_ld_be (
        .ppp      (ld_ppp),
        .ww       (ld_ww),
        .byteen   (ld_be),
        .reserved (ld_rsv)
    );

    ww_byteen_gen #(.NB(NB)) u_alu_be (
        .ppp      (alu_ppp),
        .ww       (alu_ww),
        .byteen   (alu_be),
        .reserved (alu_rsv)
    );

    wb_entry_t ld_e, alu_e;
    logic      ld_acc, alu_acc, viol;

    assign ld_e    = '{rd: ld_rd, data: ld_data, byteen: ld_be};
    assign alu_e   = '{rd: alu_rd, data: alu_data, byteen: alu_be};
    assign ld_acc  = ld_valid && !stall && !ld_rsv;
    assign alu_acc = alu_valid && !stall && !alu_rsv;
    assign viol    = (stall && (ld_valid || alu_valid)) ||
                     (!stall && ((ld_valid && ld_rsv) || (alu_valid && alu_rsv)));

    // Oldest-first candidate list: queued entries, then load, then ALU.
    // Slot 0 goes to the write port this edge, the rest stay queued.
    wb_entry_t  cand [4];
    logic [2:0] cand_n;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) cand[i] = '0;
        cand_n = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (i < q_cnt) begin
                cand[cand_n[1:0]] = q[i];
                cand_n = cand_n + 3'd1;
            end
        end
        if (ld_acc) begin
            cand[cand_n[1:0]] = ld_e;
            cand_n = cand_n + 3'd1;
        end
        if (alu_acc) begin
            cand[cand_n[1:0]] = alu_e;
            cand_n = cand_n + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q[0]     <= '0;
            q[1]     <= '0;
            q_cnt    <= '0;
            stall    <= 1'b0;
            wren     <= 1'b0;
            wraddr   <= '0;
            wrdata   <= '0;
            wrbyteen <= '0;
            err      <= 1'b0;
        end else begin
            if (viol) err <= 1'b1;
            if (cand_n != 3'd0) begin
                wren     <= 1'b1;
                wraddr   <= cand[0].rd;
                wrdata   <= cand[0].data;
                wrbyteen <= cand[0].byteen;
            end else begin
                wren     <= 1'b0;
            end
            q[0]  <= cand[1];
            q[1]  <= cand[2];
            q_cnt <= (cand_n == 3'd0) ? 2'd0 : 2'(cand_n - 3'd1);
            stall <= (cand_n > 3'd1);
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (i < q_cnt) pending[q[i].rd] = 1'b1;
        end
        if (wren) pending[wraddr] = 1'b1;
    end

endmodule

// File: tb/tb_ww_writeback_stage.sv
// Self-checking bench for ww_writeback_stage: table sweep, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_ww_writeback_stage;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         alu_valid, ld_valid;
    logic [4:0]   alu_rd, ld_rd;
    logic [127:0] alu_data, ld_data;
    logic [2:0]   alu_ppp, ld_ppp;
    logic [1:0]   alu_ww, ld_ww;
    logic         stall, wren, err;
    logic [4:0]   wraddr;
    logic [127:0] wrdata;
    logic [15:0]  wrbyteen;
    logic [31:0]  pending;

    always #5 clk = ~clk;

    ww_writeback_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .alu_ppp(alu_ppp), .alu_ww(alu_ww),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_ppp(ld_ppp), .ld_ww(ld_ww),
        .stall(stall), .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .wrbyteen(wrbyteen), .pending(pending), .err(err)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [15:0] be_tab [5][4];

    typedef struct {
        logic [2:0]  ppp;
        logic [1:0]  ww;
        logic [15:0] exp_be;
    } vec_t;
    vec_t vecs [20];

    typedef struct {
        logic [4:0]   rd;
        logic [127:0] data;
        logic [15:0]  be;
    } ent_t;

    // Reference model: every accepted-but-not-yet-written result sits in mq
    ent_t         mq [$];
    logic         m_wren, m_stall, m_err;
    logic [4:0]   m_addr;
    logic [127:0] m_data;
    logic [15:0]  m_be;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        mq.delete();
        m_wren = 0; m_stall = 0; m_err = 0;
        m_addr = '0; m_data = '0; m_be = '0;
    endfunction

    function automatic void m_offer(input logic v, input logic [4:0] rd,
                                    input logic [127:0] d, input logic [2:0] p,
                                    input logic [1:0] w);
        ent_t e;
        if (!v) return;
        if (p > 3'd4) begin
            m_err = 1;
        end else begin
            e.rd = rd; e.data = d; e.be = be_tab[p][w];
            mq.push_back(e);
        end
    endfunction

    function automatic void model_edge();
        ent_t e;
        if (m_stall) begin
            if (ld_valid || alu_valid) m_err = 1;
        end else begin
            m_offer(ld_valid, ld_rd, ld_data, ld_ppp, ld_ww);
            m_offer(alu_valid, alu_rd, alu_data, alu_ppp, alu_ww);
        end
        if (mq.size() != 0) begin
            e = mq.pop_front();
            m_wren = 1; m_addr = e.rd; m_data = e.data; m_be = e.be;
        end else begin
            m_wren = 0;
        end
        m_stall = (mq.size() != 0);
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i].rd] = 1'b1;
        if (m_wren) p[m_addr] = 1'b1;
        return p;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".wren"},     wren,     m_wren);
        chk({tag, ".stall"},    stall,    m_stall);
        chk({tag, ".err"},      err,      m_err);
        chk({tag, ".pending"},  pending,  m_pending());
        chk({tag, ".wraddr"},   wraddr,   m_addr);
        chk({tag, ".wrdata"},   wrdata,   m_data);
        chk({tag, ".wrbyteen"}, wrbyteen, m_be);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        ld_valid = 0; alu_valid = 0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        be_tab = '{'{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                   '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00},
                   '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF},
                   '{16'h5555, 16'h3333, 16'h0F0F, 16'h00FF},
                   '{16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00}};
        for (int p = 0; p < 5; p++)
            for (int w = 0; w < 4; w++)
                vecs[p*4+w] = '{3'(p), 2'(w), be_tab[p][w]};

        idle();
        alu_rd = '0; ld_rd = '0; alu_data = '0; ld_data = '0;
        alu_ppp = '0; ld_ppp = '0; alu_ww = '0; ld_ww = '0;
        m_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.wren_lit", wren, 1'b0);
        rst_n = 1;

        // single ALU write to r0
        alu_valid = 1; alu_rd = 5'd0; alu_ppp = 3'b000; alu_ww = 2'b00;
        alu_data = 128'h787897ea12fec60cae787897eac22354;
        step("single");
        chk("single.wren_lit", wren, 1'b1);
        chk("single.addr_lit", wraddr, 5'd0);
        chk("single.be_lit", wrbyteen, 16'hFFFF);
        chk("single.pend0", pending[0], 1'b1);
        idle();
        step("single_after");
        chk("single_after.pend0", pending[0], 1'b0);

        // expansion sweep on the load path
        for (int i = 0; i < 20; i++) begin
            ld_valid = 1; ld_rd = 5'(i); ld_data = rand128();
            ld_ppp = vecs[i].ppp; ld_ww = vecs[i].ww;
            step("sweep");
            chk("sweep.be_tab", wrbyteen, vecs[i].exp_be);
        end
        idle();
        step("sweep_end");

        // collision: load first, ALU one cycle later
        ld_valid = 1; ld_rd = 5'd3; ld_ppp = 3'b000; ld_data = rand128();
        alu_valid = 1; alu_rd = 5'd4; alu_ppp = 3'b010; alu_data = rand128();
        step("coll0");
        chk("coll0.addr", wraddr, 5'd3);
        chk("coll0.stall", stall, 1'b1);
        chk("coll0.pend", pending, 32'h0000_0018);
        idle();
        step("coll1");
        chk("coll1.addr", wraddr, 5'd4);
        chk("coll1.stall", stall, 1'b0);
        chk("coll1.pend", pending, 32'h0000_0010);
        step("coll2");
        chk("coll2.pend", pending, 32'h0);

        // valid while stalled is dropped
        ld_valid = 1; ld_rd = 5'd5; alu_valid = 1; alu_rd = 5'd6;
        step("viol0");
        idle();
        alu_valid = 1; alu_rd = 5'd9;
        step("viol1");
        chk("viol1.err", err, 1'b1);
        chk("viol1.addr", wraddr, 5'd6);
        idle();
        step("viol2");
        chk("viol2.noextra", wren, 1'b0);

        // reserved PPP after clearing err
        rst_n = 0; #2; m_reset(); rst_n = 1;
        ld_valid = 1; ld_rd = 5'd7; ld_ppp = 3'b110;
        step("rsv");
        chk("rsv.err", err, 1'b1);
        chk("rsv.wren", wren, 1'b0);
        idle();
        step("rsv_sticky");
        chk("rsv_sticky.err", err, 1'b1);

        // back-to-back throughput
        rst_n = 0; #2; m_reset(); rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            alu_valid = 1; alu_rd = 5'(i); alu_ppp = 3'($urandom_range(0, 4));
            alu_ww = 2'($urandom_range(0, 3)); alu_data = rand128();
            step("b2b");
            chk("b2b.wren", wren, 1'b1);
            chk("b2b.addr", wraddr, 5'(i));
            chk("b2b.stall", stall, 1'b0);
        end
        idle();
        step("b2b_end");

        // async reset while two writes are in flight
        ld_valid = 1; ld_rd = 5'd12; ld_ppp = 3'b000;
        alu_valid = 1; alu_rd = 5'd13; alu_ppp = 3'b000;
        step("arst_fill");
        idle();
        #2 rst_n = 0;
        #1;
        chk("arst.wren", wren, 1'b0);
        chk("arst.stall", stall, 1'b0);
        chk("arst.pending", pending, 32'h0);
        chk("arst.wraddr", wraddr, 5'd0);
        chk("arst.wrdata", wrdata, 128'h0);
        chk("arst.wrbyteen", wrbyteen, 16'h0);
        m_reset();
        #1 rst_n = 1;
        step("arst_post");
        chk("arst_post.nowrite", wren, 1'b0);
        step("arst_post2");

        // randomized traffic, mostly honouring stall
        for (int n = 0; n < 400; n++) begin
            if (!m_stall || $urandom_range(0, 19) == 0) begin
                ld_valid = 1'($urandom_range(0, 1));
                alu_valid = 1'($urandom_range(0, 1));
            end else begin
                idle();
            end
            ld_rd = 5'($urandom); alu_rd = 5'($urandom);
            ld_data = rand128(); alu_data = rand128();
            ld_ppp = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            alu_ppp = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            ld_ww = 2'($urandom_range(0, 3)); alu_ww = 2'($urandom_range(0, 3));
            step("rand");
        end
        idle();
        step("rand_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
